// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-side types and constants: reset PC, flush-fill NOP, buffer entry record.
package riscv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned FETCH_BUF_DEPTH  = 2;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam fetch_entry_t FLUSH_ENTRY = '{instruction: NOP_INSTR, pc: 32'h0};

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of fetch entries; flush empties it and fills slots with NOPs.
module fetch_buffer
  import riscv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         valid,
  output fetch_entry_t head
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         head_ptr;
  logic         tail_ptr;
  logic         pop_eff;
  logic         push_eff;

  // With two slots the tail is head when empty or full, the other slot when one is held.
  assign tail_ptr = head_ptr ^ count[0];
  assign pop_eff  = pop & (count != 2'd0);
  assign push_eff = push & ((count < 2'(FETCH_BUF_DEPTH)) | pop_eff);
  assign valid    = (count != 2'd0);
  assign head     = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
      head_ptr <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= FLUSH_ENTRY;
      head_ptr <= 1'b0;
      count    <= '0;
    end else begin
      if (push_eff) mem[tail_ptr] <= push_entry;
      if (pop_eff) head_ptr <= ~head_ptr;
      count <= count + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and ROM front end feeding decode through a 2-entry prefetch buffer.
// Optional FETCH_PERF_COUNTERS_EN adds fetch_count / stall_count outputs.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            MEMORY_DEPTH = 128,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  fetch_fault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] word_index;
  logic                  in_range;
  logic                  pop;
  logic                  fetch;
  logic [1:0]            count;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;

  // PCs below RESET_PC wrap to huge indices and are therefore out of range.
  assign word_index  = (pc - RESET_PC) >> 2;
  assign rom_address = word_index;
  assign in_range    = word_index < DATA_WIDTH'(MEMORY_DEPTH);

  assign pop   = instr_valid & instr_ready;
  assign fetch = ~fetch_fault & in_range & ~redirect_valid
               & ((count < 2'(FETCH_BUF_DEPTH)) | pop);

  assign push_entry = '{instruction: rom_instruction, pc: pc};
  assign instr      = head.instruction;
  assign instr_pc   = head.pc;

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .valid      (instr_valid),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      fetch_fault <= |redirect_pc[1:0];
    end else if (fetch) begin
      pc <= pc + DATA_WIDTH'(4);
    end else if (!in_range) begin
      fetch_fault <= 1'b1;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic stall_full;

  assign stall_full = ~fetch_fault & in_range & ~redirect_valid
                    & (count == 2'(FETCH_BUF_DEPTH)) & ~pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch)      fetch_count <= fetch_count + 32'd1;
      if (stall_full) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
